// File: rtl/llc_lookup_arb_pkg.sv
// Shared LLC cache type definitions and the shared priority encoder used by
// the way-lookup arbiter and its winner selector.
package llc_lookup_arb_pkg;

   localparam int LLC_SET_W  = 7;
   localparam int LLC_TAG_W  = 20;
   localparam int LLC_WAY_W  = 3;
   // Widest request vector the shared priority encoder accepts.
   localparam int LLC_PENC_W = 8;

   typedef logic [LLC_SET_W-1:0] llc_set_t;
   typedef logic [LLC_TAG_W-1:0] llc_tag_t;
   typedef logic [LLC_WAY_W-1:0] llc_way_t;

   // Request captured at grant time and held for the whole transaction.
   typedef struct packed {
      llc_set_t set;
      llc_tag_t tag;
   } llc_lookup_req_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [2:0] llc_prio_enc(input logic [LLC_PENC_W-1:0] vec);
      logic [2:0] idx;
      idx = '0;
      for (int i = LLC_PENC_W - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 3'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/llc_lookup_rr_sel.sv
// Winner selector: lowest-index request at or above the pointer, wrapping to the
// lowest-index request overall. A zero pointer gives plain fixed priority.
module llc_lookup_rr_sel
   import llc_lookup_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               any,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx
);

   logic [NUM_REQ-1:0]    mask;
   logic [NUM_REQ-1:0]    req_hi;
   logic [LLC_PENC_W-1:0] pad;

   always_comb begin
      mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         mask[i] = (i >= int'(ptr));
      end
   end

   assign req_hi = req & mask;
   assign any    = |req;

   always_comb begin
      pad = '0;
      if (|req_hi) begin
         pad[NUM_REQ-1:0] = req_hi;
      end else begin
         pad[NUM_REQ-1:0] = req;
      end
      idx = ID_W'(llc_prio_enc(pad));
      gnt = '0;
      if (any) begin
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/llc_lookup_arb.sv
// LLC way-lookup arbiter: grants one requester, reads its set, strobes the
// way-lookup unit once and holds the response until consumed.
// Define LLC_LOOKUP_RR_EN for round-robin arbitration (default: fixed priority).
module llc_lookup_arb
   import llc_lookup_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  llc_set_t [NUM_REQ-1:0]    req_set,
   input  llc_tag_t [NUM_REQ-1:0]    req_tag,
   output logic                      rd_en,
   output llc_set_t                  rd_set,
   input  logic                      rd_done,
   output logic                      lookup_en,
   output llc_tag_t                  lookup_tag,
   input  llc_way_t                  lookup_way,
   input  logic                      lookup_evict,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output llc_way_t                  rsp_way,
   output logic                      rsp_evict,
   output logic [1:0]                dbg_state
);

   // Handshake: req_ready is the grant and is only ever raised in IDLE for a
   // requester whose req_valid is high in that same cycle; rsp_valid stays high
   // until a cycle with rsp_ready high, which is the consume cycle.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      LOOKUP = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_d;
   llc_lookup_req_t    req_q;
   logic [ID_W-1:0]    id_q;
   logic [ID_W-1:0]    ptr;
   logic               win_any;
   logic [NUM_REQ-1:0] win_gnt;
   logic [ID_W-1:0]    win_idx;
   logic               grant;

   llc_lookup_rr_sel #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_sel (
      .req (req_valid),
      .ptr (ptr),
      .any (win_any),
      .gnt (win_gnt),
      .idx (win_idx)
   );

   // rst gates the grant combinationally so req_ready is low throughout reset.
   assign grant = (state_q == IDLE) && win_any && !rst;

`ifdef LLC_LOOKUP_RR_EN
   logic [ID_W-1:0] ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (grant) begin
         ptr_q <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            req_q.set <= req_set[win_idx];
            req_q.tag <= req_tag[win_idx];
            id_q      <= win_idx;
         end
      end
   end

   // Outputs are decoded from the state so each strobe belongs to one state only.
   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      rd_en      = 1'b0;
      rd_set     = '0;
      lookup_en  = 1'b0;
      lookup_tag = '0;
      rsp_valid  = 1'b0;
      rsp_id     = '0;
      rsp_way    = '0;
      rsp_evict  = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant) begin
               req_ready = win_gnt;
               state_d   = READ;
            end
         end
         READ: begin
            rd_en  = 1'b1;
            rd_set = req_q.set;
            if (rd_done) begin
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            lookup_en  = 1'b1;
            lookup_tag = req_q.tag;
            state_d    = RESP;
         end
         RESP: begin
            // The lookup unit's result is flopped and lookup_en is low here,
            // so passing it straight through keeps the response stable.
            rsp_valid = 1'b1;
            rsp_id    = id_q;
            rsp_way   = lookup_way;
            rsp_evict = lookup_evict;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_llc_lookup_arb.sv
// Self-checking bench for llc_lookup_arb: table-driven cycle vectors plus
// hand-written contention and reset-in-LOOKUP sequences.
module tb_llc_lookup_arb;
   import llc_lookup_arb_pkg::*;

   localparam int NUM_REQ = 3;
   localparam int ID_W    = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   llc_set_t [NUM_REQ-1:0] req_set;
   llc_tag_t [NUM_REQ-1:0] req_tag;
   logic                   rd_en;
   llc_set_t               rd_set;
   logic                   rd_done;
   logic                   lookup_en;
   llc_tag_t               lookup_tag;
   llc_way_t               lookup_way;
   logic                   lookup_evict;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   llc_way_t               rsp_way;
   logic                   rsp_evict;
   logic [1:0]             dbg_state;

   int checks   = 0;
   int failures = 0;

   llc_lookup_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_set      (req_set),
      .req_tag      (req_tag),
      .rd_en        (rd_en),
      .rd_set       (rd_set),
      .rd_done      (rd_done),
      .lookup_en    (lookup_en),
      .lookup_tag   (lookup_tag),
      .lookup_way   (lookup_way),
      .lookup_evict (lookup_evict),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_way      (rsp_way),
      .rsp_evict    (rsp_evict),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] req_valid;
      logic       rd_done;
      logic       rsp_ready;
      llc_way_t   lk_way;
      logic       lk_evict;
      logic [2:0] e_ready;
      logic       e_rd_en;
      llc_set_t   e_rd_set;
      logic       e_lookup_en;
      llc_tag_t   e_lookup_tag;
      logic       e_rsp_valid;
      logic [1:0] e_rsp_id;
      llc_way_t   e_rsp_way;
      logic       e_rsp_evict;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input string sig, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s %s: got=%0h expected=%0h", nm, sig, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] rv, input logic rdd, input logic rr,
                      input llc_way_t lw, input logic le, input logic [2:0] er,
                      input logic erd, input llc_set_t es, input logic elk,
                      input llc_tag_t et, input logic ev, input logic [1:0] eid,
                      input llc_way_t ew, input logic eev);
      vecs.push_back('{rv, rdd, rr, lw, le, er, erd, es, elk, et, ev, eid, ew, eev});
   endtask

   task automatic check_zero(input string nm);
      chk(nm, "req_ready", 32'(req_ready), 0);
      chk(nm, "rd_en", 32'(rd_en), 0);
      chk(nm, "rd_set", 32'(rd_set), 0);
      chk(nm, "lookup_en", 32'(lookup_en), 0);
      chk(nm, "lookup_tag", 32'(lookup_tag), 0);
      chk(nm, "rsp_valid", 32'(rsp_valid), 0);
      chk(nm, "rsp_id", 32'(rsp_id), 0);
      chk(nm, "rsp_way", 32'(rsp_way), 0);
      chk(nm, "rsp_evict", 32'(rsp_evict), 0);
   endtask

   // Grant one-hot and strobe exclusivity, sampled mid-cycle after inputs settle.
   always begin
      @(negedge clk);
      #2;
      if (!rst) begin
         checks++;
         if (!$onehot0(req_ready) || (int'(rd_en) + int'(lookup_en) + int'(rsp_valid) > 1)) begin
            failures++;
            $display("FAIL excl: req_ready=%b rd_en=%b lookup_en=%b rsp_valid=%b required onehot0/exclusive",
                     req_ready, rd_en, lookup_en, rsp_valid);
         end
      end
   end

   task automatic contention();
      int exp_order[4];
      int n;
      int cyc;
      int last;
      int who;
`ifdef LLC_LOOKUP_RR_EN
      exp_order = '{0, 1, 2, 0};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 3'b111;
      rd_done   = 1'b1;
      rsp_ready = 1'b1;
      n = 0;
      cyc = 0;
      last = 0;
      while (n < 4 && cyc < 40) begin
         #1;
         if (req_ready != '0) begin
            who = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (req_ready[i]) who = i;
            end
            chk($sformatf("contend%0d", n), "winner", 32'(who), 32'(exp_order[n]));
            if (n > 0) chk($sformatf("contend%0d", n), "spacing", 32'(cyc - last), 4);
            last = cyc;
            n++;
         end
         @(negedge clk);
         cyc++;
      end
      if (n < 4) chk("contend", "grants_before_timeout", 32'(n), 4);
      req_valid = '0;
      repeat (4) @(negedge clk);
      rd_done   = 1'b0;
      rsp_ready = 1'b0;
   endtask

   task automatic reset_in_lookup(input int first_id, input logic [2:0] after_valid,
                                  input int exp_id);
      string nm;
      nm = $sformatf("rst_lookup_%0d", exp_id);
      @(negedge clk);
      req_valid    = 3'(1 << first_id);
      rd_done      = 1'b1;
      rsp_ready    = 1'b0;
      lookup_way   = 3'd5;
      lookup_evict = 1'b1;
      #1 chk(nm, "pre_grant", 32'(req_ready), 32'(1 << first_id));
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1 chk(nm, "lookup_en", 32'(lookup_en), 1);
      rst       = 1'b1;
      req_valid = after_valid;
      #1 check_zero(nm);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk(nm, "post_grant", 32'(req_ready), 32'(1 << exp_id));
      chk(nm, "post_rsp_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk(nm, "rsp_valid", 32'(rsp_valid), 1);
      chk(nm, "rsp_id", 32'(rsp_id), 32'(exp_id));
      @(negedge clk);
      rsp_ready    = 1'b0;
      rd_done      = 1'b0;
      lookup_way   = '0;
      lookup_evict = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      req_valid    = '1;
      rd_done      = 1'b1;
      rsp_ready    = 1'b1;
      lookup_way   = 3'd7;
      lookup_evict = 1'b1;
      req_set[0] = 7'd5;   req_tag[0] = 20'h1A;
      req_set[1] = 7'd9;   req_tag[1] = 20'h2B;
      req_set[2] = 7'd12;  req_tag[2] = 20'h3C;

      //   rv   rdd rr  lw  le | ready rd set  lk tag     v  id way ev
      // single request, two-cycle read
      add(3'b001, 0, 0, 0, 0,   3'b001, 0, 0,  0, 0,     0, 0, 0, 0);
      add(3'b000, 0, 0, 0, 0,   3'b000, 1, 5,  0, 0,     0, 0, 0, 0);
      add(3'b000, 1, 0, 0, 0,   3'b000, 1, 5,  0, 0,     0, 0, 0, 0);
      add(3'b000, 0, 0, 0, 0,   3'b000, 0, 0,  1, 'h1A,  0, 0, 0, 0);
      add(3'b000, 0, 1, 5, 1,   3'b000, 0, 0,  0, 0,     1, 0, 5, 1);
      add(3'b000, 0, 0, 5, 1,   3'b000, 0, 0,  0, 0,     0, 0, 0, 0);
      // zero-wait read for requester 2
      add(3'b100, 1, 0, 0, 0,   3'b100, 0, 0,  0, 0,     0, 0, 0, 0);
      add(3'b000, 1, 0, 0, 0,   3'b000, 1, 12, 0, 0,     0, 0, 0, 0);
      add(3'b000, 0, 0, 0, 0,   3'b000, 0, 0,  1, 'h3C,  0, 0, 0, 0);
      add(3'b000, 0, 1, 2, 0,   3'b000, 0, 0,  0, 0,     1, 2, 2, 0);
      add(3'b000, 0, 0, 0, 0,   3'b000, 0, 0,  0, 0,     0, 0, 0, 0);
      // backpressure: five RESP cycles without rsp_ready, requester 0 drops out
      add(3'b010, 0, 0, 0, 0,   3'b010, 0, 0,  0, 0,     0, 0, 0, 0);
      add(3'b010, 1, 0, 0, 0,   3'b000, 1, 9,  0, 0,     0, 0, 0, 0);
      add(3'b010, 0, 0, 0, 0,   3'b000, 0, 0,  1, 'h2B,  0, 0, 0, 0);
      for (int k = 0; k < 5; k++)
         add(3'b011, 0, 0, 6, 1, 3'b000, 0, 0, 0, 0,     1, 1, 6, 1);
      add(3'b011, 0, 1, 6, 1,   3'b000, 0, 0,  0, 0,     1, 1, 6, 1);
      add(3'b000, 0, 0, 6, 1,   3'b000, 0, 0,  0, 0,     0, 0, 0, 0);

      repeat (2) @(negedge clk);
      #1 check_zero("reset");
      @(negedge clk);
      rst          = 1'b0;
      req_valid    = '0;
      rd_done      = 1'b0;
      rsp_ready    = 1'b0;
      lookup_way   = '0;
      lookup_evict = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         @(negedge clk);
         req_valid    = vecs[i].req_valid;
         rd_done      = vecs[i].rd_done;
         rsp_ready    = vecs[i].rsp_ready;
         lookup_way   = vecs[i].lk_way;
         lookup_evict = vecs[i].lk_evict;
         #1;
         chk(nm, "req_ready", 32'(req_ready), 32'(vecs[i].e_ready));
         chk(nm, "rd_en", 32'(rd_en), 32'(vecs[i].e_rd_en));
         chk(nm, "rd_set", 32'(rd_set), 32'(vecs[i].e_rd_set));
         chk(nm, "lookup_en", 32'(lookup_en), 32'(vecs[i].e_lookup_en));
         chk(nm, "lookup_tag", 32'(lookup_tag), 32'(vecs[i].e_lookup_tag));
         chk(nm, "rsp_valid", 32'(rsp_valid), 32'(vecs[i].e_rsp_valid));
         chk(nm, "rsp_id", 32'(rsp_id), 32'(vecs[i].e_rsp_id));
         chk(nm, "rsp_way", 32'(rsp_way), 32'(vecs[i].e_rsp_way));
         chk(nm, "rsp_evict", 32'(rsp_evict), 32'(vecs[i].e_rsp_evict));
      end

      contention();
      // First pass leaves a non-zero pointer behind; second pass shows it restarts at 0.
      reset_in_lookup(1, 3'b010, 1);
      reset_in_lookup(1, 3'b101, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/llc_lookup_arb.md
LLC_LOOKUP_ARB -- requirements
Module: llc_lookup_arb

Interface
REQ-001 Parameter NUM_REQ, default 3, SHALL set the number of requesters sharing the way-lookup resource (2..8).
REQ-002 Parameter ID_W, default $clog2(NUM_REQ), SHALL set the requester-ID width.
REQ-003 Clocking and reset SHALL be one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 req_valid  in  NUM_REQ  per-requester lookup request.
REQ-007 req_ready  out  NUM_REQ  per-requester grant/accept; at most one bit high in any cycle.
REQ-008 req_set  in  NUM_REQ x llc_set_t  set to look up.
REQ-009 req_tag  in  NUM_REQ x llc_tag_t  tag to look up.
REQ-010 rd_en  out  1  tag/state buffer read request.
REQ-011 rd_set  out  llc_set_t  set address for rd_en.
REQ-012 rd_done  in  1  buffers hold the set contents.
REQ-013 lookup_en  out  1  one-cycle strobe to the way-lookup unit.
REQ-014 lookup_tag  out  llc_tag_t  tag to the way-lookup unit.
REQ-015 lookup_way  in  llc_way_t  flopped way result.
REQ-016 lookup_evict  in  1  flopped evict flag.
REQ-017 rsp_valid  out  1  result available.
REQ-018 rsp_ready  in  1  result consumed.
REQ-019 rsp_id  out  ID_W  index of the granted requester.
REQ-020 rsp_way  out  llc_way_t  way result.
REQ-021 rsp_evict  out  1  eviction-required flag.

Function
REQ-022 The FSM SHALL have four states: IDLE, READ, LOOKUP, RESP.
REQ-023 In IDLE with any req_valid, the block SHALL assert req_ready for exactly one winner in the same cycle, latch its set, tag and ID, and enter READ.
REQ-024 In READ, rd_en SHALL be high with rd_set equal to the latched set until the cycle rd_done is high; the next state SHALL then be LOOKUP.
REQ-025 rd_done in the same cycle as the first rd_en SHALL be legal (one READ cycle).
REQ-026 In LOOKUP, lookup_en SHALL be high for exactly one cycle with lookup_tag equal to the latched tag; the next state SHALL be RESP.
REQ-027 In RESP, rsp_valid SHALL be high and rsp_way/rsp_evict SHALL drive lookup_way/lookup_evict directly; these are stable because lookup_en is low.
REQ-028 rsp_id SHALL equal the latched ID.
REQ-029 The block SHALL stay in RESP until rsp_ready is high, then enter IDLE.
REQ-030 req_ready SHALL be low outside IDLE.
REQ-031 Minimum grant-to-grant spacing SHALL be 4 cycles (IDLE, READ, LOOKUP, RESP).
REQ-032 A req_valid that drops while not granted SHALL be legal; that requester SHALL lose its turn without error.
REQ-033 rd_en, lookup_en and rsp_valid SHALL be mutually exclusive.

Reset
REQ-034 While rst is high, the block SHALL be in IDLE with outputs 0: req_ready, rd_en, rd_set, lookup_en, lookup_tag, rsp_valid, rsp_id, rsp_way and rsp_evict.
REQ-035 While rst is high, the round-robin pointer SHALL be 0.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction with no response issued.

Configuration
REQ-037 With LLC_LOOKUP_RR_EN defined, arbitration SHALL be round-robin: the search starts at the pointer, and the pointer becomes (winner+1) mod NUM_REQ on each grant.
REQ-038 Without LLC_LOOKUP_RR_EN, arbitration SHALL be fixed priority with the lowest index winning, and no pointer register SHALL be present.

Structure
REQ-039 llc_set_t, llc_tag_t and llc_way_t SHALL come from the shared cache type definitions.
REQ-040 The FSM state enum SHALL be local to the module.
REQ-041 Winner selection SHALL be a sub-module, llc_lookup_rr_sel (request vector and pointer in, one-hot grant and index out), reusing the shared priority encoder.

Verification
REQ-042 Single request: req_valid=001, set=5, tag=0x1A, rd_done after 2 cycles -> rd_set=5 held 2 cycles, one lookup_en with tag 0x1A, rsp_id=0, rsp_way=lookup_way.
REQ-043 Contention with LLC_LOOKUP_RR_EN: req_valid=111 held -> grant order 0,1,2,0; without the macro -> 0,0,0.
REQ-044 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid held; rsp_way/rsp_evict stable; no req_ready; no second lookup_en.
REQ-045 Zero-wait read: rd_done high with the first rd_en -> lookup_en on the next cycle, rsp_valid the cycle after.
REQ-046 Reset in LOOKUP: rst pulse -> all outputs 0 at once; a pending req_valid=010 after release -> grant 1 with the pointer restarted at 0.
REQ-047 Bench assertions: req_ready one-hot or zero; rd_en, lookup_en and rsp_valid never concurrent.
